// File: rtl/noc_traffic_ip.sv
// NoC endpoint traffic generator/checker for one router local port.
// TX emits numbered packets with idle gaps; RX checks destination, flit order and length.
module noc_traffic_ip #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned COORD_W         = 7,
    parameter int unsigned X_CUR           = 0,
    parameter int unsigned Y_CUR           = 0,
    parameter int unsigned X_DES           = 1,
    parameter int unsigned Y_DES           = 1,
    parameter int unsigned FLITS_PER_PKT   = 4,
    parameter int unsigned MAX_SEND_PACKET = 5,
    parameter int unsigned GAP_CYCLES      = 30
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  send_en,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    input  logic                  tx_ready,
    input  logic                  rx_en,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_last,
    output logic                  rx_ready,
    input  logic                  clear_err,
    output logic [15:0]           send_cnt,
    output logic [15:0]           recv_cnt,
    output logic                  send_done,
    output logic                  dest_err,
    output logic                  seq_err,
    output logic                  len_err,
    output logic                  error_flag
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLITS_PER_PKT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SEND_PACKET);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} tx_state_t;

    tx_state_t              state, state_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [7:0]             seq, seq_n;
    logic [GAP_W-1:0]       gap_cnt, gap_n;
    logic [CNT_W-1:0]       send_cnt_n;
    logic                   tx_valid_n, tx_last_n, send_done_n;
    logic [DATA_WIDTH-1:0]  tx_data_n;
    logic                   tx_acc, can_start;

    function automatic logic [DATA_WIDTH-1:0] make_flit(input logic [7:0] seq_v,
                                                        input logic [IDX_W-1:0] idx_v);
        logic [DATA_WIDTH-1:0] f;
        f = '0;
        f[DATA_WIDTH-1 -: COORD_W]           = COORD_W'(X_DES);
        f[DATA_WIDTH-1-COORD_W -: COORD_W]   = COORD_W'(Y_DES);
        f[DATA_WIDTH-1-2*COORD_W -: COORD_W] = COORD_W'(X_CUR);
        f[DATA_WIDTH-1-3*COORD_W -: COORD_W] = COORD_W'(Y_CUR);
        f[15:8] = seq_v;
        f[7:0]  = idx_v;
        return f;
    endfunction

    assign tx_acc    = tx_valid & tx_ready;
    assign can_start = (MAX_SEND_PACKET == 0) || (send_cnt < MAX_CNT);

    // TX state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_n;
    end

    // TX next state; a zero gap skips the GAP state entirely
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (send_en && can_start) state_n = ST_SEND;
            ST_SEND: if (tx_acc && tx_last)    state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (gap_cnt == GAP_END)   state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // TX datapath and next values of the registered outputs
    always_comb begin
        idx_n      = idx;
        seq_n      = seq;
        gap_n      = gap_cnt;
        send_cnt_n = send_cnt;
        case (state)
            ST_SEND: begin
                if (tx_acc) begin
                    if (tx_last) begin
                        idx_n      = '0;
                        seq_n      = seq + 8'd1;
                        send_cnt_n = send_cnt + CNT_W'(1);
                        gap_n      = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            ST_GAP:  gap_n = gap_cnt + GAP_W'(1);
            default: begin
                idx_n = '0;
                gap_n = '0;
            end
        endcase
        tx_valid_n  = (state_n == ST_SEND);
        tx_last_n   = tx_valid_n && (idx_n == LAST_IDX);
        tx_data_n   = tx_valid_n ? make_flit(seq_n, idx_n) : '0;
        send_done_n = send_done | ((MAX_SEND_PACKET != 0) && (send_cnt_n == MAX_CNT));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx       <= '0;
            seq       <= '0;
            gap_cnt   <= '0;
            send_cnt  <= '0;
            send_done <= 1'b0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
            tx_data   <= '0;
        end else begin
            idx       <= idx_n;
            seq       <= seq_n;
            gap_cnt   <= gap_n;
            send_cnt  <= send_cnt_n;
            send_done <= send_done_n;
            tx_valid  <= tx_valid_n;
            tx_last   <= tx_last_n;
            tx_data   <= tx_data_n;
        end
    end

    // RX checker
    logic [IDX_W-1:0]   exp_idx, exp_idx_n;
    logic [CNT_W-1:0]   recv_cnt_n;
    logic               rx_acc, dest_bad, seq_bad, len_bad;
    logic               dest_err_n, seq_err_n, len_err_n;
    logic [COORD_W-1:0] rx_xd, rx_yd;
    logic               unused_rx_bits;

    assign rx_xd          = rx_data[DATA_WIDTH-1 -: COORD_W];
    assign rx_yd          = rx_data[DATA_WIDTH-1-COORD_W -: COORD_W];
    assign unused_rx_bits = ^rx_data[DATA_WIDTH-1-2*COORD_W:8];
    assign rx_acc         = rx_valid & rx_ready;

    always_comb begin
        dest_bad   = rx_acc && ((rx_xd != COORD_W'(X_CUR)) || (rx_yd != COORD_W'(Y_CUR)));
        seq_bad    = rx_acc && (rx_data[IDX_W-1:0] != exp_idx);
        len_bad    = rx_acc && (rx_last != (exp_idx == LAST_IDX));
        exp_idx_n  = exp_idx;
        recv_cnt_n = recv_cnt;
        if (rx_acc) begin
            // a missing last still realigns the expected index at the packet boundary
            if (rx_last || (exp_idx == LAST_IDX)) exp_idx_n = '0;
            else                                  exp_idx_n = exp_idx + IDX_W'(1);
            if (rx_last) recv_cnt_n = recv_cnt + CNT_W'(1);
        end
        dest_err_n = (dest_err & ~clear_err) | dest_bad;
        seq_err_n  = (seq_err  & ~clear_err) | seq_bad;
        len_err_n  = (len_err  & ~clear_err) | len_bad;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_ready   <= 1'b0;
            exp_idx    <= '0;
            recv_cnt   <= '0;
            dest_err   <= 1'b0;
            seq_err    <= 1'b0;
            len_err    <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            rx_ready   <= rx_en;
            exp_idx    <= exp_idx_n;
            recv_cnt   <= recv_cnt_n;
            dest_err   <= dest_err_n;
            seq_err    <= seq_err_n;
            len_err    <= len_err_n;
            error_flag <= dest_err_n | seq_err_n | len_err_n;
        end
    end

endmodule
